// File: rtl/if_cic_decim.sv
// if_cic_decim: N-stage CIC decimator with programmable gain shift and output saturation
module if_cic_decim #(
   parameter int IN_W   = 4,
   parameter int OUT_W  = 6,
   parameter int STAGES = 3,
   parameter int DECIM  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IN_W-1:0]  in_sample,
   input  logic             in_valid,
   input  logic [1:0]       gain_spi,
   output logic [OUT_W-1:0] out_sample,
   output logic             out_valid
);
   localparam int LD    = $clog2(DECIM);
   localparam int ACC_W = IN_W + STAGES*LD;
   localparam int SW    = $clog2(ACC_W) + 1;
   localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((2**(OUT_W-1)) - 1);
   localparam logic signed [ACC_W-1:0] MINV = ~MAXV;
   logic signed [ACC_W-1:0] integ [STAGES];
   logic signed [ACC_W-1:0] dly   [STAGES];
   logic signed [ACC_W-1:0] x     [STAGES+1];
   logic signed [ACC_W-1:0] y;
   logic [OUT_W-1:0] sat;
   logic [SW-1:0] sh;
   logic [LD-1:0] cnt;
   logic strobe;
   assign strobe = in_valid && cnt == LD'(DECIM-1);
   assign x[0] = integ[STAGES-1];
   for (genvar i = 0; i < STAGES; i++) begin : g_comb
      assign x[i+1] = x[i] - dly[i];
   end
   assign sh  = SW'(ACC_W-OUT_W) - SW'({gain_spi, 1'b0});
   assign y   = x[STAGES] >>> sh;
   assign sat = y > MAXV ? OUT_W'(MAXV) : y < MINV ? OUT_W'(MINV) : OUT_W'(y);
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) begin
            integ[k] <= '0;
            dly[k]   <= '0;
         end
         cnt        <= '0;
         out_sample <= '0;
         out_valid  <= 1'b0;
      end else begin
         out_valid <= strobe;
         if (in_valid) begin
            integ[0] <= integ[0] + ACC_W'($signed(in_sample));
            for (int k = 1; k < STAGES; k++) integ[k] <= integ[k] + integ[k-1];
            cnt <= cnt + 1'b1;
         end
         if (strobe) begin
            for (int k = 0; k < STAGES; k++) dly[k] <= x[k];
            out_sample <= sat;
         end
      end
   end
endmodule

// File: tb/tb_if_cic_decim.sv
// tb_if_cic_decim: directed vectors for the CIC decimator, checked against hand values and an unwrapped integer model
module tb_if_cic_decim;
   localparam int IN_W   = 4;
   localparam int OUT_W  = 6;
   localparam int STAGES = 3;
   localparam int DECIM  = 8;
   localparam int ACC_W  = IN_W + STAGES*$clog2(DECIM);
   localparam longint MAXO = 2**(OUT_W-1) - 1;
   localparam longint MINO = -(2**(OUT_W-1));
   logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0;
   logic [IN_W-1:0] in_sample = '0;
   logic [1:0] gain_spi = '0;
   logic [OUT_W-1:0] out_sample;
   logic out_valid;
   if_cic_decim #(.IN_W(IN_W), .OUT_W(OUT_W), .STAGES(STAGES), .DECIM(DECIM)) dut (
      .clk(clk), .rst_n(rst_n), .in_sample(in_sample), .in_valid(in_valid),
      .gain_spi(gain_spi), .out_sample(out_sample), .out_valid(out_valid)
   );
   always #5 clk = ~clk;
   int n_vec = 0, n_bad = 0;
   longint mi [STAGES];
   longint md [STAGES];
   int mcnt, n_out;
   logic exp_valid;
   longint exp_out;
   typedef struct {int s; int per; logic [1:0] g; int want;} vec_t;
   vec_t tbl [10];
   task automatic check(input string name, input longint got, input longint want);
      n_vec++;
      if (got != want) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", name, got, want);
      end
   endtask
   task automatic model_reset();
      for (int k = 0; k < STAGES; k++) begin
         mi[k] = 0;
         md[k] = 0;
      end
      mcnt = 0;
      n_out = 0;
      exp_out = 0;
      exp_valid = 1'b0;
   endtask
   task automatic do_reset(input int n);
      in_valid = 1'b0;
      rst_n = 1'b0;
      repeat (n) @(posedge clk);
      #1;
      model_reset();
      check("rst_out_sample", longint'($signed(out_sample)), 0);
      check("rst_out_valid", longint'(out_valid), 0);
      rst_n = 1'b1;
   endtask
   // Model keeps full-precision sums; the true comb output fits ACC_W, so RTL wrap must be invisible.
   task automatic step(input int s, input logic v, input logic [1:0] g);
      longint xv, p;
      in_sample = IN_W'(s);
      in_valid = v;
      gain_spi = g;
      @(posedge clk);
      exp_valid = 1'b0;
      if (v) begin
         if (mcnt == DECIM-1) begin
            xv = mi[STAGES-1];
            for (int k = 0; k < STAGES; k++) begin
               p = xv;
               xv = xv - md[k];
               md[k] = p;
            end
            xv = xv >>> (ACC_W - OUT_W - 2*int'(g));
            exp_out = xv > MAXO ? MAXO : xv < MINO ? MINO : xv;
            exp_valid = 1'b1;
         end
         for (int k = STAGES-1; k > 0; k--) mi[k] += mi[k-1];
         mi[0] += longint'(s);
         mcnt = (mcnt + 1) % DECIM;
      end
      #1;
      check("out_valid", longint'(out_valid), longint'(exp_valid));
      if (exp_valid) begin
         n_out++;
         check("out_sample", longint'($signed(out_sample)), exp_out);
      end
   endtask
   initial begin
      tbl[0] = '{s:  7, per: 1, g: 2'd0, want:  28};
      tbl[1] = '{s: -8, per: 1, g: 2'd0, want: -32};
      tbl[2] = '{s:  7, per: 1, g: 2'd1, want:  31};
      tbl[3] = '{s: -8, per: 1, g: 2'd3, want: -32};
      tbl[4] = '{s:  0, per: 1, g: 2'd0, want:   0};
      tbl[5] = '{s:  7, per: 3, g: 2'd0, want:  28};
      tbl[6] = '{s: -1, per: 1, g: 2'd0, want:  -4};
      tbl[7] = '{s: -1, per: 1, g: 2'd1, want: -16};
      tbl[8] = '{s:  1, per: 2, g: 2'd3, want:  31};
      tbl[9] = '{s:  3, per: 1, g: 2'd2, want:  31};
      model_reset();
      do_reset(4);
      for (int c = 0; c < 100; c++) step(5, 1'b0, 2'd0);
      foreach (tbl[i]) begin
         do_reset(2);
         for (int c = 0; c < 6*DECIM*tbl[i].per; c++) begin
            step(c % tbl[i].per == 0 ? tbl[i].s : 0, c % tbl[i].per == 0, tbl[i].g);
            if (exp_valid && n_out >= 4) check("settled", longint'($signed(out_sample)), longint'(tbl[i].want));
         end
         check("output_count", longint'(n_out), 6);
      end
      do_reset(1);
      for (int c = 0; c < 64; c++) begin
         step(7, 1'b1, c >= 44 ? 2'd1 : 2'd0);
         if (c == 43) check("gain_before", longint'($signed(out_sample)), 28);
      end
      check("gain_after", longint'($signed(out_sample)), 31);
      do_reset(1);
      for (int c = 0; c < 20000; c++) begin
         step(7, 1'b1, 2'd0);
         if (exp_valid && n_out >= 4) check("dc_wrap", longint'($signed(out_sample)), 28);
      end
      for (int c = 0; c < 4096; c++) step((c / 256) % 2 != 0 ? -8 : 7, 1'b1, 2'd0);
      do_reset(1);
      for (int c = 0; c < 5; c++) step(7, 1'b1, 2'd0);
      do_reset(1);
      for (int c = 0; c < 7; c++) step(7, 1'b1, 2'd0);
      check("mid_rst_no_early", longint'(out_valid), 0);
      step(7, 1'b1, 2'd0);
      check("mid_rst_strobe", longint'(out_valid), 1);
      step(7, 1'b1, 2'd0);
      check("strobe_one_cycle", longint'(out_valid), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
